// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive block: register map, bit indices, FSM states.
package uart_rx_pkg;

   localparam logic [3:0] REG_RX_DATA = 4'h0;
   localparam logic [3:0] REG_STATUS  = 4'h4;
   localparam logic [3:0] REG_CTRL    = 4'h8;
   localparam logic [3:0] REG_CLKDIV  = 4'hC;

   localparam int ST_NOT_EMPTY = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVERRUN   = 2;
   localparam int ST_FRAME_ERR = 3;
   localparam int ST_PAR_ERR   = 4;
   localparam int ST_COUNT_LSB = 8;

   localparam int CTRL_RX_EN   = 0;
   localparam int CTRL_IRQ_EN  = 1;
   localparam int CTRL_PAR_EN  = 2;
   localparam int CTRL_PAR_ODD = 3;

   localparam int DIV_MIN = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } rx_state_t;

   // Expected parity bit: even parity makes the total count of ones even.
   function automatic logic parity_bit(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO with power-of-two depth; push when full is refused unless a pop frees a slot.
module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // NOTE: storage has no reset; only the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/uart_rx_fifo_wb.sv
// UART 8N1 receiver with RX FIFO, Wishbone registers and level interrupt.
// Define UART_RX_PARITY_EN to add the optional parity stage (CTRL par_en/par_odd, STATUS par_err).
module uart_rx_fifo_wb
   import uart_rx_pkg::*;
#(
   parameter int               FIFO_DEPTH = 8,
   parameter int               DIV_W      = 16,
   parameter logic [DIV_W-1:0] DIV_RESET  = DIV_W'(347),
   parameter logic [31:0]      BASE_ADR   = 32'h3000_0000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic        rx_i,
   output logic        irq_o,
   output logic        rx_busy_o
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   rx_state_t        state, state_next;
   logic             rx_meta, rx_sync, rx_prev, rx_fall;
   logic [DIV_W-1:0] clkdiv, div_act, cnt, div_wr;
   logic             tick;
   logic [2:0]       bitcnt;
   logic [7:0]       shreg, fifo_head;
   logic             rx_en, irq_en, overrun, frame_err, par_err, par_bad;
   logic             push_req, frame_bad, pop_pend, fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             hit, accept, wr;
   logic [3:0]       off;
   logic [31:0]      rdata;
   logic             unused_ok;

   assign unused_ok = &{1'b0, wbs_dat_i[31:16], wbs_sel_i[3:2]};

   // NOTE: all state uses synchronous reset and non-blocking assignments.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) {rx_meta, rx_sync, rx_prev} <= 3'b111;
      else          {rx_meta, rx_sync, rx_prev} <= {rx_i, rx_meta, rx_sync};
   end
   assign rx_fall = rx_prev & ~rx_sync;
   assign tick    = (cnt == '0);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= S_IDLE;
      else          state <= state_next;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (rx_en && rx_fall) state_next = S_START;
         S_START: if (tick) state_next = rx_sync ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
         S_DATA:   if (tick && bitcnt == 3'd7) state_next = par_en ? S_PARITY : S_STOP;
         S_PARITY: if (tick) state_next = S_STOP;
`else
         S_DATA:  if (tick && bitcnt == 3'd7) state_next = S_STOP;
`endif
         S_STOP:  if (tick) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      rx_busy_o = (state != S_IDLE);
      push_req  = 1'b0;
      frame_bad = 1'b0;
      if (tick && state == S_STOP) begin
         push_req  = rx_sync & ~par_bad;
         frame_bad = ~rx_sync;
      end
   end

   // Divider counts down to 0 and reloads div-1, so each bit spans exactly CLKDIV clocks.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         cnt     <= '0;
         bitcnt  <= '0;
         shreg   <= '0;
         div_act <= DIV_RESET;
      end else if (state == S_IDLE) begin
         if (rx_en && rx_fall) begin
            cnt     <= clkdiv >> 1;
            div_act <= clkdiv;
            bitcnt  <= '0;
         end
      end else if (tick) begin
         cnt <= div_act - DIV_W'(1);
         if (state == S_DATA) begin
            shreg  <= {rx_sync, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
         end
      end else begin
         cnt <= cnt - DIV_W'(1);
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_en, par_odd, par_fail;
   assign par_fail = tick && (state == S_PARITY) && (rx_sync != parity_bit(shreg, par_odd));

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)               par_bad <= 1'b0;
      else if (state == S_START)  par_bad <= 1'b0;
      else if (par_fail)          par_bad <= 1'b1;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         par_en  <= 1'b0;
         par_odd <= 1'b0;
         par_err <= 1'b0;
      end else begin
         if (wr && wbs_sel_i[0] && off == REG_CTRL) begin
            par_en  <= wbs_dat_i[CTRL_PAR_EN];
            par_odd <= wbs_dat_i[CTRL_PAR_ODD];
         end
         if (par_fail) par_err <= 1'b1;
         else if (wr && wbs_sel_i[0] && off == REG_STATUS && wbs_dat_i[ST_PAR_ERR]) par_err <= 1'b0;
      end
   end
`else
   assign par_bad = 1'b0;
   assign par_err = 1'b0;
`endif

   uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8), .CNT_W(CNT_W)) u_fifo (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .push      (push_req),
      .push_data (shreg),
      .pop       (pop_pend),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign hit    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
   assign accept = hit & ~wbs_ack_o;
   assign wr     = accept & wbs_we_i;
   assign off    = wbs_adr_i[3:0];

   always_comb begin
      rdata = '0;
      case (off)
         REG_RX_DATA: if (!fifo_empty) rdata[7:0] = fifo_head;
         REG_STATUS: begin
            rdata[ST_NOT_EMPTY]             = ~fifo_empty;
            rdata[ST_FULL]                  = fifo_full;
            rdata[ST_OVERRUN]               = overrun;
            rdata[ST_FRAME_ERR]             = frame_err;
            rdata[ST_PAR_ERR]               = par_err;
            rdata[ST_COUNT_LSB +: CNT_W]    = fifo_count;
         end
         REG_CTRL: begin
            rdata[CTRL_RX_EN]  = rx_en;
            rdata[CTRL_IRQ_EN] = irq_en;
`ifdef UART_RX_PARITY_EN
            rdata[CTRL_PAR_EN]  = par_en;
            rdata[CTRL_PAR_ODD] = par_odd;
`endif
         end
         REG_CLKDIV: rdata[DIV_W-1:0] = clkdiv;
         default:    rdata = '0;
      endcase
   end

   // Byte-lane merge of a CLKDIV write; lanes 0 and 1 only.
   always_comb begin
      div_wr = clkdiv;
      for (int i = 0; i < DIV_W; i++) begin
         if ((i < 8 && wbs_sel_i[0]) || (i >= 8 && i < 16 && wbs_sel_i[1])) div_wr[i] = wbs_dat_i[i];
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         pop_pend  <= 1'b0;
         rx_en     <= 1'b0;
         irq_en    <= 1'b0;
         clkdiv    <= DIV_RESET;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         irq_o     <= 1'b0;
      end else begin
         wbs_ack_o <= accept;
         wbs_dat_o <= (accept && !wbs_we_i) ? rdata : '0;
         pop_pend  <= accept && !wbs_we_i && off == REG_RX_DATA && !fifo_empty;
         if (wr && wbs_sel_i[0] && off == REG_CTRL) begin
            rx_en  <= wbs_dat_i[CTRL_RX_EN];
            irq_en <= wbs_dat_i[CTRL_IRQ_EN];
         end
         if (wr && off == REG_CLKDIV && |wbs_sel_i[1:0])
            clkdiv <= (div_wr < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_wr;
         if (push_req && fifo_full && !pop_pend) overrun <= 1'b1;
         else if (wr && wbs_sel_i[0] && off == REG_STATUS && wbs_dat_i[ST_OVERRUN]) overrun <= 1'b0;
         if (frame_bad) frame_err <= 1'b1;
         else if (wr && wbs_sel_i[0] && off == REG_STATUS && wbs_dat_i[ST_FRAME_ERR]) frame_err <= 1'b0;
         irq_o <= irq_en & (~fifo_empty | overrun | frame_err | par_err);
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo_wb.sv
// Directed bench for uart_rx_fifo_wb; parity cases run when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo_wb;

   localparam logic [31:0] BASE    = 32'h3000_0000;
   localparam logic [31:0] A_DATA  = BASE + 32'h0;
   localparam logic [31:0] A_STAT  = BASE + 32'h4;
   localparam logic [31:0] A_CTRL  = BASE + 32'h8;
   localparam logic [31:0] A_DIV   = BASE + 32'hC;
   localparam int          BIT_CYC = 16;

   logic        wb_clk_i, wb_rst_i;
   logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
   logic        wbs_ack_o, rx_i, irq_o, rx_busy_o;

   int vectors = 0;
   int miscompares = 0;

   uart_rx_fifo_wb dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .rx_i      (rx_i),
      .irq_o     (irq_o),
      .rx_busy_o (rx_busy_o)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                          input logic [3:0] sel, output logic [31:0] rdata, output logic acked);
      wbs_adr_i = adr;
      wbs_dat_i = wdata;
      wbs_we_i  = we;
      wbs_sel_i = sel;
      wbs_stb_i = 1'b1;
      wbs_cyc_i = 1'b1;
      acked     = 1'b0;
      rdata     = '0;
      for (int k = 0; k < 4 && !acked; k++) begin
         @(negedge wb_clk_i);
         if (wbs_ack_o) begin
            acked = 1'b1;
            rdata = wbs_dat_o;
         end
      end
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_we_i  = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
      logic [31:0] d;
      logic        a;
      wb_xfer(1'b0, adr, '0, 4'hF, d, a);
      if (!a) check({tag, "_ack"}, 32'(a), 32'd1);
      else    check(tag, d, exp);
   endtask

   task automatic wb_wr(input logic [31:0] adr, input logic [31:0] data);
      logic [31:0] d;
      logic        a;
      wb_xfer(1'b1, adr, data, 4'hF, d, a);
      if (!a) check("write_ack", 32'(a), 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge wb_clk_i);
   endtask

   // Drives one frame; abort_at >= 0 pulses reset halfway through that frame bit.
   task automatic send_frame(input logic [7:0] data, input logic par_on, input logic par_b,
                             input logic stop_b, input int abort_at);
      logic [10:0] frame;
      int          n;
      frame = '1;
      frame[0] = 1'b0;
      frame[8:1] = data;
      if (par_on) begin
         frame[9]  = par_b;
         frame[10] = stop_b;
         n = 11;
      end else begin
         frame[9] = stop_b;
         n = 10;
      end
      for (int i = 0; i < n; i++) begin
         rx_i = frame[i];
         for (int c = 0; c < BIT_CYC; c++) begin
            @(negedge wb_clk_i);
            if (i == abort_at && c == BIT_CYC / 2) begin
               wb_rst_i = 1'b1;
               @(negedge wb_clk_i);
               check("busy_after_reset", 32'(rx_busy_o), 32'd0);
               wb_rst_i = 1'b0;
            end
         end
      end
      rx_i = 1'b1;
      idle(6);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      wb_rst_i  = 1'b1;
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_we_i  = 1'b0;
      wbs_sel_i = 4'h0;
      wbs_adr_i = '0;
      wbs_dat_i = '0;
      rx_i      = 1'b1;
      idle(3);
      wb_rst_i = 1'b0;
      idle(1);

      // Reset state
      check("rst_irq", 32'(irq_o), 32'd0);
      check("rst_busy", 32'(rx_busy_o), 32'd0);
      check("rst_ack", 32'(wbs_ack_o), 32'd0);
      rd_chk("rst_status", A_STAT, 32'h0);
      rd_chk("rst_clkdiv", A_DIV, 32'd347);
      rd_chk("rst_ctrl", A_CTRL, 32'h0);
      rd_chk("empty_read", A_DATA, 32'h0);
      rd_chk("unmapped_read", BASE + 32'h2, 32'h0);

      // Address outside the block: no acknowledge
      begin
         logic [31:0] d;
         logic        a;
         wb_xfer(1'b0, BASE + 32'h10, '0, 4'hF, d, a);
         check("foreign_no_ack", 32'(a), 32'd0);
      end

      // Divider clamp and configuration
      wb_wr(A_DIV, 32'd2);
      rd_chk("clkdiv_clamp", A_DIV, 32'd4);
      wb_wr(A_DIV, 32'd16);
      rd_chk("clkdiv_16", A_DIV, 32'd16);
      wb_wr(A_CTRL, 32'hF);
`ifdef UART_RX_PARITY_EN
      rd_chk("ctrl_all", A_CTRL, 32'hF);
`else
      rd_chk("ctrl_masked", A_CTRL, 32'h3);
`endif
      wb_wr(A_CTRL, 32'h3);

      // Single byte
      send_frame(8'h3D, 1'b0, 1'b0, 1'b1, -1);
      check("irq_byte", 32'(irq_o), 32'd1);
      rd_chk("status_one", A_STAT, 32'h101);
      rd_chk("data_3d", A_DATA, 32'h3D);
      rd_chk("status_drained", A_STAT, 32'h0);
      idle(2);
      check("irq_drained", 32'(irq_o), 32'd0);

      // Overrun: nine bytes into an eight-entry FIFO
      for (int b = 0; b < 9; b++) send_frame(8'(b), 1'b0, 1'b0, 1'b1, -1);
      rd_chk("status_full", A_STAT, 32'h807);
      for (int b = 0; b < 8; b++) rd_chk($sformatf("ovr_data%0d", b), A_DATA, 32'(b));
      rd_chk("status_ovr_only", A_STAT, 32'h4);
      idle(2);
      check("irq_ovr", 32'(irq_o), 32'd1);
      wb_wr(A_STAT, 32'h4);
      rd_chk("status_ovr_clr", A_STAT, 32'h0);
      idle(2);
      check("irq_ovr_clr", 32'(irq_o), 32'd0);

      // Framing error: line low for a whole frame
      rx_i = 1'b0;
      idle(10 * BIT_CYC);
      rx_i = 1'b1;
      idle(6);
      rd_chk("status_frame_err", A_STAT, 32'h8);
      check("irq_frame_err", 32'(irq_o), 32'd1);
      wb_wr(A_STAT, 32'h8);
      rd_chk("status_fe_clr", A_STAT, 32'h0);

      // Short glitch is rejected at the start-bit midpoint
      rx_i = 1'b0;
      idle(6);
      rx_i = 1'b1;
      check("glitch_busy", 32'(rx_busy_o), 32'd1);
      idle(20);
      check("glitch_idle", 32'(rx_busy_o), 32'd0);
      rd_chk("glitch_status", A_STAT, 32'h0);

      // Reset during data bit 4 aborts the frame
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 5);
      rd_chk("post_rst_clkdiv", A_DIV, 32'd347);
      rd_chk("post_rst_status", A_STAT, 32'h0);
      wb_wr(A_DIV, 32'd16);
      wb_wr(A_CTRL, 32'h3);
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
      rd_chk("status_a5", A_STAT, 32'h101);
      rd_chk("data_a5", A_DATA, 32'hA5);

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x3D has five ones, so the parity bit must be 1
      wb_wr(A_CTRL, 32'h7);
      send_frame(8'h3D, 1'b1, 1'b0, 1'b1, -1);
      rd_chk("status_par_err", A_STAT, 32'h10);
      check("irq_par_err", 32'(irq_o), 32'd1);
      wb_wr(A_STAT, 32'h10);
      rd_chk("status_par_clr", A_STAT, 32'h0);
      send_frame(8'h3D, 1'b1, 1'b1, 1'b1, -1);
      rd_chk("status_par_ok", A_STAT, 32'h101);
      rd_chk("data_par_ok", A_DATA, 32'h3D);
`else
      wb_wr(A_STAT, 32'h10);
      rd_chk("status_no_par", A_STAT, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
